// File: rtl/seg_pkg.sv
// seg_pkg: shared types and segment patterns for the seven-segment display blocks.
// Patterns are active-low, bit order gfedcba.
package seg_pkg;
   typedef logic [3:0] bcd_t;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [9:0][6:0] DIGIT_TABLE = {
      7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
      7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low seven-segment decoder.
// Non-decimal codes show a dash so bad data is visible rather than misleading.
module bcd_to_seg
   import seg_pkg::*;
(
   input  bcd_t       bcd_i,
   output logic [6:0] seg_o
);
   assign seg_o = (bcd_i > 4'd9) ? SEG_DASH : DIGIT_TABLE[bcd_i];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans four BCD digits onto a common-anode display.
// Digits are snapshotted once per frame; each slot opens with blanking; optional blink.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGIT_TICKS  = 100000,
   parameter int BLANK_TICKS  = 1000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic       clk,
   input  logic       reset,
   input  bcd_t       bin0,
   input  bcd_t       bin1,
   input  bcd_t       bin2,
   input  bcd_t       bin3,
   input  logic       blink,
   output logic [6:0] seg,
   output logic [3:0] AN,
   output logic       frame
);
   localparam int CW = $clog2(DIGIT_TICKS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(DIGIT_TICKS - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_TICKS);
   localparam logic [FW-1:0] FC_MAX    = FW'(BLINK_FRAMES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   bcd_t [3:0]    shadow_q, shadow_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic          vis_q, vis_d;
   logic [6:0]    seg_q, seg_d, dec_seg;
   logic [3:0]    an_q, an_d;
   logic          frame_q, frame_d;
   logic          last, wrap, fc_wrap, blank_d;

   bcd_to_seg u_dec (
      .bcd_i (shadow_d[idx_d]),
      .seg_o (dec_seg)
   );

   // outputs are decoded from next-state so they line up with the state they describe
   always_comb begin
      last        = cnt_q == CNT_MAX;
      wrap        = last && idx_q == 2'd3;
      fc_wrap     = frame_cnt_q == FC_MAX;
      cnt_d       = last ? '0 : cnt_q + 1'b1;
      idx_d       = last ? idx_q + 2'd1 : idx_q;
      shadow_d    = wrap ? {bin3, bin2, bin1, bin0} : shadow_q;
      frame_d     = wrap;
      frame_cnt_d = !blink ? '0 : wrap ? (fc_wrap ? '0 : frame_cnt_q + 1'b1) : frame_cnt_q;
      vis_d       = !blink ? 1'b1 : (wrap && fc_wrap) ? !vis_q : vis_q;
      blank_d     = cnt_d < BLANK_END || !vis_d;
      an_d        = blank_d ? 4'b1111 : ~(4'b0001 << idx_d);
      seg_d       = blank_d ? SEG_BLANK : dec_seg;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         frame_cnt_q <= '0;
         vis_q       <= 1'b1;
         seg_q       <= SEG_BLANK;
         an_q        <= 4'b1111;
         frame_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         frame_cnt_q <= frame_cnt_d;
         vis_q       <= vis_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         frame_q     <= frame_d;
      end
   end

   assign seg   = seg_q;
   assign AN    = an_q;
   assign frame = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized self-checking bench against an edge-count reference model.
// Model position is derived arithmetically from the number of edges since reset.
module tb_seg_scan_driver;
   localparam int DT = 8, BT = 2, BF = 2;
   localparam logic [6:0] DIG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   logic clk = 0, reset = 1, blink = 0;
   logic [3:0] bin0 = 0, bin1 = 0, bin2 = 0, bin3 = 0;
   logic [6:0] seg;
   logic [3:0] AN;
   logic frame;
   int tests = 0, fails = 0;
   int n, bfr;
   logic [3:0] snap [4];
   logic exp_frame;

   always #5 clk = ~clk;

   seg_scan_driver #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .reset(reset), .bin0(bin0), .bin1(bin1), .bin2(bin2), .bin3(bin3),
      .blink(blink), .seg(seg), .AN(AN), .frame(frame)
   );

   function automatic bit vis();
      return ((bfr / BF) % 2) == 0;
   endfunction
   function automatic int pos();
      return n % DT;
   endfunction
   function automatic int dig();
      return (n / DT) % 4;
   endfunction
   function automatic logic [3:0] exp_an();
      if (pos() < BT || !vis()) return 4'b1111;
      return ~(4'b0001 << dig());
   endfunction
   function automatic logic [6:0] exp_seg();
      if (pos() < BT || !vis()) return 7'b1111111;
      return snap[dig()] > 4'd9 ? 7'b0111111 : DIG[snap[dig()]];
   endfunction

   task automatic model_reset();
      n = 0; bfr = 0; exp_frame = 0;
      foreach (snap[k]) snap[k] = 4'd0;
   endtask

   task automatic tick();
      bit wrap;
      n++;
      wrap = (n % (4 * DT)) == 0;
      exp_frame = wrap;
      if (wrap) begin
         snap[0] = bin0; snap[1] = bin1; snap[2] = bin2; snap[3] = bin3;
      end
      if (!blink) bfr = 0;
      else if (wrap) bfr++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 reset = 0;
      #1 tests++;
      if (AN !== 4'b1111 || seg !== 7'b1111111 || frame !== 1'b0) begin
         fails++; $display("FAIL reset_hold AN=%b seg=%b frame=%b want 1111/1111111/0", AN, seg, frame);
      end
      @(posedge clk); #1 reset = 1;
      model_reset();
      repeat (DT) begin
         tick();
         tests++;
         if (AN !== exp_an() || seg !== exp_seg() || frame !== exp_frame) begin
            fails++; $display("FAIL reset_slot n=%0d AN=%b/%b seg=%b/%b frame=%b/%b", n, AN, exp_an(), seg, exp_seg(), frame, exp_frame);
         end
         if (n == 2) begin
            tests++;
            if (AN !== 4'b1110 || seg !== 7'b1000000) begin
               fails++; $display("FAIL reset_first_digit AN=%b seg=%b want 1110/1000000", AN, seg);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      int pulses = 0;
      bin3 = 5; bin2 = 9; bin1 = 5; bin0 = 9;
      while (n < 3 * 4 * DT) begin
         tick();
         tests++;
         if (AN !== exp_an() || seg !== exp_seg() || frame !== exp_frame) begin
            fails++; $display("FAIL snapshot n=%0d AN=%b/%b seg=%b/%b frame=%b/%b", n, AN, exp_an(), seg, exp_seg(), frame, exp_frame);
         end
         if (frame === 1'b1 && n <= 4 * DT) pulses++;
         if (n == 4 * DT + DT + 3) begin
            tests++;
            if (AN !== 4'b1101 || seg !== 7'b0010010) begin
               fails++; $display("FAIL snapshot_digit1 AN=%b seg=%b want 1101/0010010", AN, seg);
            end
         end
      end
      tests++;
      if (pulses != 1) begin
         fails++; $display("FAIL frame_pulse_count got %0d want 1", pulses);
      end
   endtask

   task automatic test_tear_free();
      for (int k = 0; k < 4 * DT && dig() != 1; k++) tick();
      bin2 = 4;
      repeat (2 * 4 * DT) begin
         tick();
         tests++;
         if (AN !== exp_an() || seg !== exp_seg() || frame !== exp_frame) begin
            fails++; $display("FAIL tear_free n=%0d AN=%b/%b seg=%b/%b frame=%b/%b", n, AN, exp_an(), seg, exp_seg(), frame, exp_frame);
         end
      end
   endtask

   task automatic test_invalid_bcd();
      int dashes = 0;
      bin1 = 4'hC;
      repeat (2 * 4 * DT) begin
         tick();
         tests++;
         if (AN !== exp_an() || seg !== exp_seg() || frame !== exp_frame) begin
            fails++; $display("FAIL invalid_bcd n=%0d AN=%b/%b seg=%b/%b frame=%b/%b", n, AN, exp_an(), seg, exp_seg(), frame, exp_frame);
         end
         if (AN === 4'b1101 && seg === 7'b0111111) dashes++;
      end
      tests++;
      if (dashes < DT - BT) begin
         fails++; $display("FAIL invalid_dash_cycles got %0d want >= %0d", dashes, DT - BT);
      end
   endtask

   task automatic test_blink();
      int dark = 0;
      for (int k = 0; k < 4 * DT && (n % (4 * DT)) != 4 * DT - 1; k++) tick();
      blink = 1;
      repeat (5 * 4 * DT) begin
         tick();
         tests++;
         if (AN !== exp_an() || seg !== exp_seg() || frame !== exp_frame) begin
            fails++; $display("FAIL blink n=%0d AN=%b/%b seg=%b/%b frame=%b/%b", n, AN, exp_an(), seg, exp_seg(), frame, exp_frame);
         end
         if (!vis()) dark++;
      end
      tests++;
      if (dark != 2 * 4 * DT) begin
         fails++; $display("FAIL blink_dark_cycles got %0d want %0d", dark, 2 * 4 * DT);
      end
      for (int k = 0; k < 8 * 4 * DT && vis(); k++) tick();
      blink = 0;
      repeat (2 * DT) begin
         tick();
         tests++;
         if (AN !== exp_an() || seg !== exp_seg() || frame !== exp_frame) begin
            fails++; $display("FAIL blink_release n=%0d AN=%b/%b seg=%b/%b frame=%b/%b", n, AN, exp_an(), seg, exp_seg(), frame, exp_frame);
         end
      end
   endtask

   task automatic test_random();
      repeat (1200) begin
         if ($urandom_range(0, 7) == 0) bin0 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) bin1 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) bin2 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) bin3 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) blink = ~blink;
         tick();
         tests++;
         if (AN !== exp_an() || seg !== exp_seg() || frame !== exp_frame) begin
            fails++; $display("FAIL random n=%0d AN=%b/%b seg=%b/%b frame=%b/%b", n, AN, exp_an(), seg, exp_seg(), frame, exp_frame);
         end
         tests++;
         if (pos() < BT ? AN !== 4'b1111 : (vis() && $countones(~AN) != 1)) begin
            fails++; $display("FAIL ghosting n=%0d AN=%b", n, AN);
         end
      end
      blink = 0;
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 4 * DT && !(dig() == 1 && pos() >= BT); k++) tick();
      #2 reset = 0;
      #1 tests++;
      if (AN !== 4'b1111 || seg !== 7'b1111111 || frame !== 1'b0) begin
         fails++; $display("FAIL async_reset AN=%b seg=%b frame=%b want 1111/1111111/0", AN, seg, frame);
      end
      @(posedge clk); #1 reset = 1;
      model_reset();
      repeat (5 * DT) begin
         tick();
         tests++;
         if (AN !== exp_an() || seg !== exp_seg() || frame !== exp_frame) begin
            fails++; $display("FAIL after_reset n=%0d AN=%b/%b seg=%b/%b frame=%b/%b", n, AN, exp_an(), seg, exp_seg(), frame, exp_frame);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_snapshot();
      test_tear_free();
      test_invalid_bcd();
      test_blink();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
